// File: rtl/sisc_sequencer.sv
// sisc_sequencer: multicycle control sequencer for the SISC datapath.
// Each instruction moves through FETCH/DECODE/EXECUTE/(MEM)/WRITEBACK.
// The sequencer drives every datapath strobe and resolves branch
// conditions against the status flags.
// Ports:
//   clk, rst_f            clock; asynchronous active-low reset
//   opcode, mm, stat      ir[31:28], ir[27:24], status flags {C,N,V,Z}
//   ir_load .. dm_we      datapath control strobes (Moore outputs)
//   halted                high while the core is stopped on HLT
//   illegal               sticky flag, set when an undefined opcode is decoded
//   icount                saturating count of retired instructions
module sisc_sequencer #(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [3:0]        opcode,
  input  logic [3:0]        mm,
  input  logic [3:0]        stat,
  output logic              ir_load,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              br_sel,
  output logic              pc_rst,
  output logic              rd_sel,
  output logic [1:0]        alu_op,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              dm_we,
  output logic              halted,
  output logic              illegal,
  output logic [ICNT_W-1:0] icount
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALR = 4'b0001;
  localparam logic [3:0] OP_ALI = 4'b0010;
  localparam logic [3:0] OP_BRA = 4'b0100;
  localparam logic [3:0] OP_BRR = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_BNR = 4'b0111;
  localparam logic [3:0] OP_LOD = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state, next;

  logic legal;
  logic hit;
  logic taken;

  always_comb begin
    case (opcode)
      OP_NOP, OP_ALR, OP_ALI, OP_BRA, OP_BRR,
      OP_BNE, OP_BNR, OP_LOD, OP_STR, OP_HLT: legal = 1'b1;
      default:                                 legal = 1'b0;
    endcase
  end

  // BRA/BRR with an empty mask are unconditional.
  assign hit = |(mm & stat);
  always_comb begin
    case (opcode)
      OP_BRA, OP_BRR: taken = (mm == 4'b0000) || hit;
      OP_BNE, OP_BNR: taken = !hit;
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= S_START;
      illegal <= 1'b0;
      icount  <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE && !legal)
        illegal <= 1'b1;
      if (state == S_WB && icount != {ICNT_W{1'b1}})
        icount <= icount + 1'b1;
    end
  end

  always_comb begin
    next     = state;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    rd_sel   = 1'b0;
    alu_op   = 2'b00;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_START: begin
        pc_rst = 1'b1;
        next   = S_FETCH;
      end
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        next     = S_DECODE;
      end
      S_DECODE: next = (opcode == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        // Illegal opcodes fall through the default arm and behave as NOP.
        case (opcode)
          OP_ALR: alu_op = 2'b00;
          OP_ALI: alu_op = 2'b01;
          OP_LOD: alu_op = 2'b10;
          OP_STR: begin
            alu_op = 2'b10;
            rd_sel = 1'b1;
          end
          OP_BRA, OP_BRR, OP_BNE, OP_BNR: begin
            pc_sel   = 1'b1;
            br_sel   = (opcode == OP_BRR) || (opcode == OP_BNR);
            pc_write = taken;
          end
          default: ;
        endcase
        next = (opcode == OP_LOD || opcode == OP_STR) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_op = 2'b10;
        if (opcode == OP_STR) begin
          rd_sel = 1'b1;
          dm_we  = 1'b1;
        end
        next = S_WB;
      end
      S_WB: begin
        case (opcode)
          OP_ALR: rf_we = 1'b1;
          OP_ALI: begin
            rf_we  = 1'b1;
            alu_op = 2'b01;
          end
          OP_LOD: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
          end
          default: ;
        endcase
        next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: next = S_START;
    endcase
  end

endmodule
